// File: rtl/elevator_pkg.sv
// Shared types for the elevator scheduler: car state encodings and travel direction.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package elevator_pkg;

   // Encodings are visible on the sim_state output and consumed by the display side.
   typedef enum logic [1:0] {
      IDLE        = 2'b00,
      MOVING_UP   = 2'b01,
      MOVING_DOWN = 2'b10,
      DOOR_OPEN   = 2'b11
   } sim_state_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   localparam int MAX_FLOORS = 16;

endpackage

// File: rtl/elevator_req_search.sv
// Pending-request search around a floor: any request above, any below, one here.
// Latency: purely combinational.
// Backpressure: none.
// Ports: pending (request bitmask), cur_floor (floor to search around) ->
//        any_above, any_below, here.
module elevator_req_search
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = 16,
   parameter int FW         = $clog2(NUM_FLOORS)
) (
   input  logic [NUM_FLOORS-1:0] pending,
   input  logic [FW-1:0]         cur_floor,
   output logic                  any_above,
   output logic                  any_below,
   output logic                  here
);

   if (NUM_FLOORS < 2 || NUM_FLOORS > MAX_FLOORS) begin : g_bad_floors
      $error("elevator_req_search: NUM_FLOORS out of range");
   end

   always_comb begin
      any_above = 1'b0;
      any_below = 1'b0;
      for (int f = 0; f < NUM_FLOORS; f++) begin
         if (pending[f] && (f > int'(cur_floor))) any_above = 1'b1;
         if (pending[f] && (f < int'(cur_floor))) any_below = 1'b1;
      end
   end

   assign here = pending[cur_floor];

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN elevator controller: latches floor calls, steps the car one floor per travel interval, holds doors.
// Latency: a request is visible on destination one cycle after its pulse; motion/door timing advances on tick.
// Backpressure: none; requests are always accepted (OR-ed into the pending mask).
// Ports: clk, rst (sync active-high), tick (timing enable), req (call pulses) ->
//        destination (pending mask), sim_state, cur_floor, door_open.
// Optional: ELEVATOR_ESTOP_EN adds input estop, which freezes state, floor and counters while high.
module elevator_scheduler
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS   = 16,
   parameter int TRAVEL_TICKS = 4,
   parameter int DOOR_TICKS   = 6
) (
   input  logic                          clk,
   input  logic                          rst,
`ifdef ELEVATOR_ESTOP_EN
   input  logic                          estop,
`endif
   input  logic                          tick,
   input  logic [NUM_FLOORS-1:0]         req,
   output logic [NUM_FLOORS-1:0]         destination,
   output logic [1:0]                    sim_state,
   output logic [$clog2(NUM_FLOORS)-1:0] cur_floor,
   output logic                          door_open
);

   localparam int FW      = $clog2(NUM_FLOORS);
   localparam int CNT_MAX = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
   localparam int CW      = $clog2(CNT_MAX) + 1;

   sim_state_t            state_q, state_d;
   dir_t                  dir_q, dir_d;
   logic [FW-1:0]         floor_q, floor_d;
   logic [NUM_FLOORS-1:0] pend_q, pend_d;
   logic [CW-1:0]         travel_cnt_q, travel_cnt_d;
   logic [CW-1:0]         door_cnt_q, door_cnt_d;

   logic                  freeze;
   logic                  adv;
   logic                  moving;
   logic                  arrive;
   logic [FW-1:0]         search_floor;
   logic [NUM_FLOORS-1:0] search_onehot;
   logic [NUM_FLOORS-1:0] pend_all;
   logic                  any_above, any_below, here;

`ifdef ELEVATOR_ESTOP_EN
   assign freeze = estop;
`else
   assign freeze = 1'b0;
`endif

   assign adv    = tick & ~freeze;
   assign moving = (state_q == MOVING_UP) || (state_q == MOVING_DOWN);
   assign arrive = adv && moving && (travel_cnt_q == CW'(TRAVEL_TICKS - 1));

   // All decisions in a cycle concern a single floor: the floor being arrived at
   // on a terminal travel tick, otherwise the floor the car is on.
   always_comb begin
      search_floor = floor_q;
      if (arrive) begin
         search_floor = (state_q == MOVING_UP) ? floor_q + FW'(1) : floor_q - FW'(1);
      end
      search_onehot = NUM_FLOORS'(1) << search_floor;
   end

   // Same-cycle requests take part in decisions, so a call landing on the arrival
   // floor stops the car. Calls for the floor whose door is open are dropped.
   assign pend_all = (pend_q | req) & ~((state_q == DOOR_OPEN) ? search_onehot : '0);

   elevator_req_search #(
      .NUM_FLOORS (NUM_FLOORS),
      .FW         (FW)
   ) u_search (
      .pending   (pend_all),
      .cur_floor (search_floor),
      .any_above (any_above),
      .any_below (any_below),
      .here      (here)
   );

   always_comb begin
      state_d      = state_q;
      dir_d        = dir_q;
      floor_d      = floor_q;
      pend_d       = pend_all;
      travel_cnt_d = travel_cnt_q;
      door_cnt_d   = door_cnt_q;

      case (state_q)
         IDLE: begin
            if (!freeze) begin
               if (here) begin
                  state_d = DOOR_OPEN;
                  pend_d  = pend_all & ~search_onehot;
               end else if (any_above && any_below) begin
                  state_d = (dir_q == DIR_UP) ? MOVING_UP : MOVING_DOWN;
               end else if (any_above) begin
                  state_d = MOVING_UP;
                  dir_d   = DIR_UP;
               end else if (any_below) begin
                  state_d = MOVING_DOWN;
                  dir_d   = DIR_DOWN;
               end
            end
         end

         MOVING_UP, MOVING_DOWN: begin
            if (arrive) begin
               travel_cnt_d = '0;
               floor_d      = search_floor;
               if (here) begin
                  state_d = DOOR_OPEN;
                  pend_d  = pend_all & ~search_onehot;
               end else if ((state_q == MOVING_UP) ? any_above : any_below) begin
                  state_d = state_q;
               end else begin
                  state_d = IDLE;
               end
            end else if (adv) begin
               travel_cnt_d = travel_cnt_q + CW'(1);
            end
         end

         DOOR_OPEN: begin
            if (adv) begin
               if (door_cnt_q == CW'(DOOR_TICKS - 1)) begin
                  door_cnt_d = '0;
                  state_d    = IDLE;
               end else begin
                  door_cnt_d = door_cnt_q + CW'(1);
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         dir_q        <= DIR_UP;
         floor_q      <= '0;
         pend_q       <= '0;
         travel_cnt_q <= '0;
         door_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         dir_q        <= dir_d;
         floor_q      <= floor_d;
         pend_q       <= pend_d;
         travel_cnt_q <= travel_cnt_d;
         door_cnt_q   <= door_cnt_d;
      end
   end

   assign destination = pend_q;
   assign sim_state   = state_q;
   assign cur_floor   = floor_q;
   // Only DOOR_OPEN drives the door, so a frozen moving car always reports it closed.
   assign door_open   = (state_q == DOOR_OPEN);

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler with hand-computed expectations.
// Latency: n/a.
// Backpressure: n/a.
module tb_elevator_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        tick;
   logic [15:0] req;
   logic [15:0] destination;
   logic [1:0]  sim_state;
   logic [3:0]  cur_floor;
   logic        door_open;
`ifdef ELEVATOR_ESTOP_EN
   logic        estop;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   elevator_scheduler #(
      .NUM_FLOORS   (16),
      .TRAVEL_TICKS (4),
      .DOOR_TICKS   (6)
   ) dut (
      .clk         (clk),
      .rst         (rst),
`ifdef ELEVATOR_ESTOP_EN
      .estop       (estop),
`endif
      .tick        (tick),
      .req         (req),
      .destination (destination),
      .sim_state   (sim_state),
      .cur_floor   (cur_floor),
      .door_open   (door_open)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance n clock edges; outputs are then sampled 1 time unit after the edge.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst  = 1'b1;
      tick = 1'b0;
      req  = '0;
`ifdef ELEVATOR_ESTOP_EN
      estop = 1'b0;
`endif

      // 1: reset state
      cyc(2);
      rst = 1'b0;
      cyc(1);
      check("rst_dest",  destination, 32'h0);
      check("rst_state", sim_state,   32'h0);
      check("rst_floor", cur_floor,   32'h0);
      check("rst_door",  door_open,   32'h0);

      // 2: call floor 5 from floor 0, tick every cycle
      tick = 1'b1;
      req  = 16'h0020;
      cyc(1);
      req = '0;
      check("t2_dest_latched", destination, 32'h0020);
      check("t2_moving_up",    sim_state,   32'h1);
      cyc(19);
      check("t2_floor4",       cur_floor,   32'h4);
      check("t2_still_moving", sim_state,   32'h1);
      cyc(1);
      check("t2_floor5",       cur_floor,   32'h5);
      check("t2_door_state",   sim_state,   32'h3);
      check("t2_door_open",    door_open,   32'h1);
      check("t2_dest_cleared", destination, 32'h0);
      cyc(5);
      check("t2_door_held",    sim_state,   32'h3);
      cyc(1);
      check("t2_idle",         sim_state,   32'h0);
      check("t2_door_closed",  door_open,   32'h0);

      // 3: at floor 5 with calls at 8 and 2, direction UP -> 8 first, then 2
      req = 16'h0104;
      cyc(1);
      req = '0;
      check("t3_up",         sim_state,   32'h1);
      check("t3_dest",       destination, 32'h0104);
      cyc(11);
      check("t3_floor7",     cur_floor,   32'h7);
      cyc(1);
      check("t3_floor8",     cur_floor,   32'h8);
      check("t3_door8",      sim_state,   32'h3);
      check("t3_dest_left2", destination, 32'h0004);
      cyc(6);
      check("t3_idle8",      sim_state,   32'h0);
      cyc(1);
      check("t3_down",       sim_state,   32'h2);
      cyc(23);
      check("t3_floor3",     cur_floor,   32'h3);
      check("t3_still_down", sim_state,   32'h2);
      cyc(1);
      check("t3_floor2",     cur_floor,   32'h2);
      check("t3_door2",      sim_state,   32'h3);
      check("t3_dest_empty", destination, 32'h0);
      cyc(6);
      check("t3_idle2",      sim_state,   32'h0);

      // move to floor 0 for the next case
      req = 16'h0001;
      cyc(1);
      req = '0;
      check("t4pre_down",  sim_state, 32'h2);
      cyc(8);
      check("t4pre_floor0", cur_floor, 32'h0);
      check("t4pre_door",   sim_state, 32'h3);
      cyc(6);
      check("t4pre_idle",   sim_state, 32'h0);

      // 4: call the current floor while idle, then again while the door is open
      req = 16'h0001;
      cyc(1);
      req = '0;
      check("t4_door_now",    sim_state,   32'h3);
      check("t4_no_travel",   cur_floor,   32'h0);
      check("t4_dest_zero",   destination, 32'h0);
      cyc(1);
      req = 16'h0001;
      cyc(1);
      req = '0;
      check("t4_absorbed",    destination, 32'h0);
      cyc(3);
      check("t4_door_held",   sim_state,   32'h3);
      cyc(1);
      check("t4_closed_sched", sim_state,  32'h0);
      check("t4_door_low",    door_open,   32'h0);
      check("t4_dest_final",  destination, 32'h0);

      // 5: reset between floors 3 and 4
      req = 16'h0400;
      cyc(1);
      req = '0;
      check("t5_up",       sim_state,   32'h1);
      cyc(13);
      check("t5_floor3",   cur_floor,   32'h3);
      check("t5_pending",  destination, 32'h0400);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      check("t5_rst_dest",  destination, 32'h0);
      check("t5_rst_state", sim_state,   32'h0);
      check("t5_rst_floor", cur_floor,   32'h0);
      check("t5_rst_door",  door_open,   32'h0);
      cyc(2);
      check("t5_stay_idle", sim_state,   32'h0);
      check("t5_stay_dest", destination, 32'h0);

`ifdef ELEVATOR_ESTOP_EN
      // 6: emergency stop for 10 ticks mid-travel toward floor 3
      req = 16'h0008;
      cyc(1);
      req = '0;
      check("t6_up", sim_state, 32'h1);
      cyc(5);
      estop = 1'b1;
      req   = 16'h0200;
      cyc(1);
      req = '0;
      cyc(9);
      check("t6_frozen_floor", cur_floor,   32'h1);
      check("t6_frozen_state", sim_state,   32'h1);
      check("t6_frozen_door",  door_open,   32'h0);
      check("t6_req_captured", destination, 32'h0208);
      estop = 1'b0;
      cyc(6);
      check("t6_floor2",       cur_floor,   32'h2);
      check("t6_moving",       sim_state,   32'h1);
      cyc(1);
      check("t6_floor3",       cur_floor,   32'h3);
      check("t6_door3",        sim_state,   32'h3);
      check("t6_dest9",        destination, 32'h0200);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
Elevator motion controller that produces the `destination` and `sim_state` inputs consumed by `vgaController`; it is the producing end of that display interface.
- Latches floor-call requests into a pending bitmask.
- Serves requests with a SCAN (keep-direction) policy.
- Steps the car one floor per travel interval and holds doors open for a fixed interval.
- All timing advances on a `tick` enable, which is driven from the `clkDivider` output.

Parameters:
- NUM_FLOORS, 16, number of floors; sets the request and destination width. Legal range 2..16.
- TRAVEL_TICKS, 4, tick count to move between adjacent floors (>=1).
- DOOR_TICKS, 6, tick count that doors stay open (>=1).

Ports:
- clk  in  1  system clock (pixel-domain clock)
- rst  in  1  synchronous, active-high reset
- tick  in  1  single-cycle timing enable; all travel/door counters advance only when high
- req  in  NUM_FLOORS  call-button pulses, one bit per floor; multiple bits per cycle allowed
- destination  out  NUM_FLOORS  pending-request bitmask; bit f = floor f requested
- sim_state  out  2  00 IDLE, 01 MOVING_UP, 10 MOVING_DOWN, 11 DOOR_OPEN
- cur_floor  out  $clog2(NUM_FLOORS)  current car floor
- door_open  out  1  high iff sim_state==DOOR_OPEN

Behaviour:
- Reset (synchronous, `rst` sampled high at a clk edge):
  - destination=0, sim_state=IDLE, cur_floor=0, door_open=0.
  - Travel and door counters = 0; direction register = UP.
  - Reset mid-travel or mid-door aborts immediately, with no partial-floor memory.
- Request capture:
  - pending <= pending | req every cycle.
  - `destination` reflects a request one cycle after the req pulse.
  - Exception: a request for cur_floor while in DOOR_OPEN is absorbed (never set) and does not restart the door timer.
- IDLE, evaluated each cycle with priority:
  - (a) pending[cur_floor] -> DOOR_OPEN, clearing that bit on entry.
  - (b) any pending above and any below -> move in the direction register's direction.
  - (c) only above -> MOVING_UP, dir=UP.
  - (d) only below -> MOVING_DOWN, dir=DOWN.
  - (e) none -> stay IDLE.
  - IDLE with work present lasts exactly one cycle.
- MOVING_UP / MOVING_DOWN:
  - On each tick the travel counter increments.
  - On the tick where it equals TRAVEL_TICKS-1: counter <= 0 and cur_floor +/- 1.
  - Arrival decision uses the new floor and the pending value of that same cycle:
    - pending[new] -> DOOR_OPEN, bit cleared;
    - else pending further in the same direction -> keep moving;
    - else -> IDLE.
  - The car never moves beyond floor 0 or NUM_FLOORS-1; it moves only toward pending bits.
- DOOR_OPEN:
  - Door counter increments on tick.
  - On the tick where it equals DOOR_TICKS-1: counter <= 0 and state -> IDLE.
- Simultaneous events: a req and a tick in the same cycle are both honoured. A request landing on the arrival floor in the arrival cycle triggers a door stop.
- Arithmetic: counters are sized $clog2(max(TRAVEL_TICKS,DOOR_TICKS))+1 and never wrap, because they are cleared at the terminal count.

Optional Feature:
Macro ELEVATOR_ESTOP_EN.
- When defined: adds input port `estop` (1 bit).
  - While estop=1, all counters freeze, the state holds, and cur_floor holds.
  - Requests are still captured.
  - Release resumes from the frozen counts.
  - While estop=1, sim_state is reported unchanged and door_open is forced to 0 if the state is moving.
- When undefined: the port is absent and behaviour is exactly as above.

Decomposition:
- Package `elevator_pkg`:
  - typedef enum logic [1:0] sim_state_t {IDLE, MOVING_UP, MOVING_DOWN, DOOR_OPEN}, with the encodings above;
  - typedef dir_t {DIR_UP, DIR_DOWN};
  - localparam MAX_FLOORS=16.
- One sub-module, `elevator_req_search`: combinational; inputs pending and cur_floor; outputs any_above, any_below, here.

Test Plan:
1. rst=1 for 2 cycles, then req=16'h0000 -> destination=0, sim_state=00, cur_floor=0, door_open=0.
2. req bit5 pulse, tick every cycle, TRAVEL_TICKS=4 -> destination=16'h0020 the next cycle; MOVING_UP; cur_floor reaches 5 after 20 ticks; then DOOR_OPEN with destination=0; IDLE after 6 more ticks.
3. Car at 5 moving up with pending {8,2} (16'h0104) -> serves 8 first, then reverses to 2; sim_state sequence 01,11,00,10,11.
4. req bit0 while idle at floor 0 -> DOOR_OPEN on the next cycle with no travel; bit0 pulsed again during the door period -> destination stays 0 and the door closes on schedule.
5. rst asserted mid-travel (between floors 3 and 4) -> the next cycle shows all outputs at reset values and pending cleared.
6. With ELEVATOR_ESTOP_EN: estop=1 for 10 ticks mid-travel -> cur_floor and counter frozen; req bit9 is still captured; the arrival floor is reached 10 ticks later than without estop.
